program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Copies a program image from the boot ROM into the core's instruction memory, one word per fixed slot of WORD_PERIOD clocks.
- A program-load button (BTN[1] at fpga_top) starts the transfer.
- Sits inside fpga_top, after the PLL and reset generator, between the boot ROM and the core's imem write port.
- Holds the core in reset until an image has been completely loaded.

Parameters:
ADDR_WIDTH, 8, width of the ROM and imem word addresses
DATA_WIDTH, 32, instruction word width
ROM_DEPTH, 256, number of words copied (1..2^ADDR_WIDTH)
WORD_PERIOD, 8, clocks per copied word (>=3); 8 gives 80 ns per word at 100 MHz

Ports:
clk  in  1  system clock (PLL output)
s_reset_n  in  1  asynchronous, active-low reset
start_btn  in  1  raw program-load button; asynchronous to clk, level
rom_addr  out  ADDR_WIDTH  boot ROM read address
rom_data  in  DATA_WIDTH  boot ROM read data, valid 1 clk after rom_addr
imem_we  out  1  instruction memory write enable, single-cycle pulse
imem_addr  out  ADDR_WIDTH  instruction memory write address
imem_wdata  out  DATA_WIDTH  instruction memory write data
core_hold  out  1  holds the core in reset while high
busy  out  1  transfer in progress
done  out  1  last transfer completed; sticky

Behaviour:
- Interface (already decided): one clock, clk; reset s_reset_n is asynchronous and active-low.
- Reset values:
  - all outputs 0 except core_hold=1;
  - FSM in IDLE, word index 0, sync flops 0.
- Start synchronisation:
  - start_btn passes through a 2-FF synchroniser, then a registered rising-edge detector;
  - one load per rising edge; holding the button does not retrigger.
- Start timing: the state leaves IDLE/DONE on the 3rd rising clk edge that samples start_btn high. Call the first busy cycle c0.
- States: IDLE, ADDR, FETCH, WRITE, GAP, DONE.
- IDLE: busy=0, done=0, core_hold=1. A start edge moves to ADDR with word index k=0.
- ADDR (1 clk): rom_addr=k.
- FETCH (1 clk): rom_data is valid; it is captured into imem_wdata and imem_addr=k.
- WRITE (1 clk):
  - imem_we=1.
  - If k==ROM_DEPTH-1, go to DONE next clk.
  - Otherwise go to GAP for WORD_PERIOD-3 clks (skip GAP when WORD_PERIOD==3), then back to ADDR with k+1.
- Per-word timing: word k has imem_we high in cycle c0+WORD_PERIOD*k+2. Default last write is at c0+2042.
- DONE:
  - busy=0, done=1, core_hold=0, entered the clk after the last write;
  - a new start edge re-enters ADDR with k=0, clears done and re-asserts core_hold in that same clk.
- Outputs while busy: busy=1 and core_hold=1 in ADDR..GAP.
- imem_we is 0 in every state except WRITE.
- imem_addr and imem_wdata hold their last values outside FETCH.
- Start edges arriving while busy are ignored and not queued.
- Word index:
  - k is ADDR_WIDTH bits;
  - it is compared against ROM_DEPTH-1 and never wraps;
  - ROM_DEPTH==2^ADDR_WIDTH must work (k stops at all-ones).
- Reset mid-transfer:
  - immediate return to IDLE with reset values (core_hold=1, done=0);
  - no imem_we glitch;
  - a partial image stays in imem and needs a fresh start edge.
- A start edge that coincides with reset deassertion is lost until the synchroniser refills.

Test Plan:
- Reset, no button -> core_hold=1, busy=0, done=0, imem_we never asserts over 1000 clks.
- ROM preloaded with word k = 32'hA500_0000+k; pulse start_btn for 10 clks -> 256 imem_we pulses spaced exactly 8 clks apart; imem_addr=k; imem_wdata=A500_0000+k; then done=1, core_hold=0, busy=0. Checked by a scoreboard imem model.
- Hold start_btn high for 5000 clks -> exactly one load of 256 writes; a second press after done -> a full reload, with core_hold=1 again during the reload.
- Toggle start_btn repeatedly at word 100 -> no restart; writes continue monotonically to 255.
- Assert s_reset_n=0 mid-write of word 50 -> all outputs go to reset values at once; after a new press, writes restart at address 0.
- ROM_DEPTH=4, WORD_PERIOD=3 -> writes at c0+2, 5, 8, 11; done at c0+12.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: copies a boot ROM image into instruction memory, one word
// per WORD_PERIOD clocks, and holds the core in reset until a full image has
// been written.
//
// Ports:
//   clk         system clock
//   s_reset_n   asynchronous active-low reset
//   start_btn   raw load button (asynchronous level, synchronised here)
//   rom_addr    boot ROM read address (current word index)
//   rom_data    boot ROM read data, valid one clock after rom_addr
//   imem_we     instruction memory write strobe (one clock per word)
//   imem_addr   instruction memory write address
//   imem_wdata  instruction memory write data
//   core_hold   keeps the core in reset while high
//   busy        transfer in progress
//   done        last word written (sticky until the next load starts)
module program_loader #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ROM_DEPTH   = 256,
  parameter int unsigned WORD_PERIOD = 8
) (
  input  logic                  clk,
  input  logic                  s_reset_n,
  input  logic                  start_btn,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_FETCH,
    S_WRITE,
    S_GAP,
    S_DONE
  } state_t;

  localparam int unsigned GAP_W = $clog2(WORD_PERIOD);
  // GAP lasts WORD_PERIOD-3 clocks; the counter runs 0 .. WORD_PERIOD-4.
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((WORD_PERIOD > 3) ? (WORD_PERIOD - 4) : 0);
  localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(ROM_DEPTH - 1);

  state_t                  state_q, state_d;
  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic                    prev_q,  prev_d;
  logic [ADDR_WIDTH-1:0]   k_q, k_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    start_edge;

  // Rising edge of the synchronised button; prev_q is the registered copy.
  assign start_edge = sync2_q & ~prev_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      k_q     <= '0;
      gap_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    sync1_d = start_btn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    k_d     = k_q;
    gap_d   = gap_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_d = S_ADDR;
          k_d     = '0;
        end
      end
      S_ADDR: state_d = S_FETCH;
      S_FETCH: begin
        state_d = S_WRITE;
        waddr_d = k_q;
        wdata_d = rom_data;
      end
      S_WRITE: begin
        gap_d = '0;
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else if (WORD_PERIOD == 3) begin
          state_d = S_ADDR;
          k_d     = k_q + ADDR_WIDTH'(1);
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_ADDR;
          k_d     = k_q + ADDR_WIDTH'(1);
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so reset cannot glitch imem_we.
  always_comb begin
    imem_we   = (state_q == S_WRITE);
    busy      = (state_q == S_ADDR) || (state_q == S_FETCH) ||
                (state_q == S_WRITE) || (state_q == S_GAP);
    done      = (state_q == S_DONE);
    core_hold = (state_q != S_DONE);
  end

  assign rom_addr   = k_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  int   cyc;
  int   vectors;
  int   miscompares;

  // Instance A: default parameters. Instance B: ROM_DEPTH=4, WORD_PERIOD=3.
  logic        rst_a, start_a, we_a, hold_a, busy_a, done_a;
  logic [7:0]  raddr_a, waddr_a;
  logic [31:0] rdata_a, wdata_a;
  logic        rst_b, start_b, we_b, hold_b, busy_b, done_b;
  logic [7:0]  raddr_b, waddr_b;
  logic [31:0] rdata_b, wdata_b;

  logic [31:0] rom_a [256];
  logic [31:0] rom_b [256];
  exp_t        qa[$];
  exp_t        qb[$];

  program_loader dut_a (
    .clk(clk), .s_reset_n(rst_a), .start_btn(start_a),
    .rom_addr(raddr_a), .rom_data(rdata_a),
    .imem_we(we_a), .imem_addr(waddr_a), .imem_wdata(wdata_a),
    .core_hold(hold_a), .busy(busy_a), .done(done_a)
  );

  program_loader #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .ROM_DEPTH(4), .WORD_PERIOD(3)
  ) dut_b (
    .clk(clk), .s_reset_n(rst_b), .start_btn(start_b),
    .rom_addr(raddr_b), .rom_data(rdata_b),
    .imem_we(we_b), .imem_addr(waddr_b), .imem_wdata(wdata_b),
    .core_hold(hold_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous boot ROMs: data valid one clock after the address.
  always @(posedge clk) begin
    rdata_a <= rom_a[raddr_a];
    rdata_b <= rom_b[raddr_b];
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a press whose first high sample is edge N starts the
  // load in cycle c0 = N+2; word k is written in cycle c0 + 2 + period*k.
  task automatic press(input bit b, input int hold, output int c0);
    int depth, period;
    exp_t e;
    @(negedge clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    c0 = cyc + 3;
    depth  = b ? 4 : 256;
    period = b ? 3 : 8;
    for (int k = 0; k < depth; k++) begin
      e.addr = 8'(k);
      e.data = b ? rom_b[k] : rom_a[k];
      e.cyc  = c0 + 2 + period * k;
      if (b) qb.push_back(e); else qa.push_back(e);
    end
    repeat (hold) @(negedge clk);
    if (b) start_b = 1'b0; else start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    int n = 0;
    while (!(done_a === 1'b1 && qa.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, 96'(n >= 3000), 96'(0));
    chk({name, "_status"}, 96'({done_a, hold_a, busy_a, we_a}), 96'(4'b1000));
  endtask

  task automatic wait_qsize_a(input int target);
    int n = 0;
    while (qa.size() > target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_word_timeout", 96'(n >= 3000), 96'(0));
  endtask

  // Monitors: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (we_a !== 1'b0) begin
      if (qa.size() == 0) begin
        chk("unexpected_write_a", 96'({waddr_a, wdata_a}), 96'(0));
      end else begin
        e = qa.pop_front();
        chk("write_a", 96'({waddr_a, wdata_a, cyc[23:0], busy_a, hold_a}),
            96'({e.addr, e.data, e.cyc[23:0], 2'b11}));
      end
    end
    if (we_b !== 1'b0) begin
      if (qb.size() == 0) begin
        chk("unexpected_write_b", 96'({waddr_b, wdata_b}), 96'(0));
      end else begin
        e = qb.pop_front();
        chk("write_b", 96'({waddr_b, wdata_b, cyc[23:0], busy_b, hold_b}),
            96'({e.addr, e.data, e.cyc[23:0], 2'b11}));
      end
    end
  end

  initial begin
    int c0, n, k;
    vectors = 0;
    miscompares = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = 32'hA500_0000 + 32'(i);
      rom_b[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    chk("reset_a", 96'({raddr_a, we_a, waddr_a, wdata_a, hold_a, busy_a, done_a}),
        96'({8'd0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
    rst_a = 1'b1; rst_b = 1'b1;

    // Idle for 1000 clocks: no writes, core held.
    for (int i = 0; i < 10; i++) begin
      repeat (100) @(negedge clk);
      chk("idle_a", 96'({hold_a, busy_a, done_a}), 96'(3'b100));
    end

    // Small instance: writes at c0+2,5,8,11 and done at c0+12.
    press(1'b1, 4, c0);
    n = 0;
    while (done_b !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_b_cycle", 96'(cyc), 96'(c0 + 12));
    chk("done_b_status", 96'({done_b, hold_b, busy_b, qb.size() == 0}), 96'(4'b1001));

    // First full load with a short random press.
    press(1'b0, $urandom_range(4, 20), c0);
    wait_done_a("load1");

    // Held button: one load only; held for 5000 clocks total.
    for (int i = 0; i < 256; i++) rom_a[i] = $urandom;
    press(1'b0, 5000, c0);
    chk("hold_once", 96'({done_a, qa.size() == 0}), 96'(2'b11));
    wait_done_a("hold");

    // Button toggling from word 100 onwards must not restart the load.
    for (int i = 0; i < 256; i++) rom_a[i] = $urandom;
    press(1'b0, $urandom_range(3, 8), c0);
    wait_qsize_a(156);
    for (int i = 0; i < 30; i++) begin
      start_a = ~start_a;
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    start_a = 1'b0;
    wait_done_a("toggle");

    // Reset during the write cycle of word 50.
    for (int i = 0; i < 256; i++) rom_a[i] = $urandom;
    press(1'b0, 5, c0);
    wait_qsize_a(206);
    k = qa[0].cyc;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cyc < k && n < 1000);
    chk("word50_we", 96'({we_a, waddr_a}), 96'({1'b1, 8'd50}));
    #1;
    rst_a = 1'b0;
    #1;
    qa.delete();
    chk("midreset_a", 96'({raddr_a, we_a, waddr_a, wdata_a, hold_a, busy_a, done_a}),
        96'({8'd0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    repeat (20) @(negedge clk);
    chk("after_reset_idle", 96'({hold_a, busy_a, done_a}), 96'(3'b100));
    press(1'b0, 6, c0);
    wait_done_a("reload");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
